// File: rtl/div_mc_pkg.sv
// div_mc_pkg: shared M-unit definitions for the multi-cycle divider.
package div_mc_pkg;

    localparam logic [2:0] DIV_F3  = 3'b100;
    localparam logic [2:0] DIVU_F3 = 3'b101;
    localparam logic [2:0] REM_F3  = 3'b110;
    localparam logic [2:0] REMU_F3 = 3'b111;

    // Widest operand abs_val handles; callers size-cast in and out.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in dividend MSB, trial subtract, select).
module div_step
    import div_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem,
    input  logic [DATA_WIDTH-1:0] dvd,
    input  logic [DATA_WIDTH-1:0] dvs,
    output logic [DATA_WIDTH:0]   rem_nxt,
    output logic [DATA_WIDTH-1:0] dvd_nxt
);

    logic [DATA_WIDTH+1:0] rem_sh;
    logic [DATA_WIDTH+1:0] diff;
    logic                  take;

    always_comb begin
        rem_sh  = {rem, dvd[DATA_WIDTH-1]};
        diff    = rem_sh - {2'b00, dvs};
        take    = ~diff[DATA_WIDTH+1];
        rem_nxt = take ? diff[DATA_WIDTH:0] : rem_sh[DATA_WIDTH:0];
        // Dividend register doubles as the quotient accumulator.
        dvd_nxt = {dvd[DATA_WIDTH-2:0], take};
    end

endmodule

// File: rtl/div_mc.sv
// div_mc: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_EARLY_OUT_EN to resolve divide-by-zero, overflow and |op1|<|op2| at issue.
module div_mc
    import div_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [2:0]            div_ctrl,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);

    div_state_t            state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH:0]   rem, rem_nxt;
    logic [DATA_WIDTH-1:0] dvd, dvd_nxt, dvs;
    logic                  neg_q, neg_r, sel_rem;
    logic                  sgn, s1, s2, accept, early;
    logic [DATA_WIDTH-1:0] a_abs, b_abs;

    assign req_ready  = state == IDLE;
    assign resp_valid = state == DONE;
    assign busy       = state != IDLE;

    assign sgn    = ~div_ctrl[0];
    assign s1     = sgn & op1[DATA_WIDTH-1];
    assign s2     = sgn & op2[DATA_WIDTH-1];
    assign a_abs  = DATA_WIDTH'(abs_val(MAX_W'(op1), s1));
    assign b_abs  = DATA_WIDTH'(abs_val(MAX_W'(op2), s2));
    assign accept = req_ready & req_valid & div_ctrl[2] & ~flush;

`ifdef DIV_EARLY_OUT_EN
    logic                  div0, ovf;
    logic [DATA_WIDTH-1:0] eo_res;
    always_comb begin
        div0   = op2 == '0;
        ovf    = sgn & (op1 == {1'b1, {(DATA_WIDTH-1){1'b0}}}) & (&op2);
        early  = div0 | ovf | (a_abs < b_abs);
        eo_res = div_ctrl[1] ? (ovf ? '0 : op1) : (div0 ? '1 : ovf ? op1 : '0);
    end
`else
    assign early = 1'b0;
`endif

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem     (rem),
        .dvd     (dvd),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .dvd_nxt (dvd_nxt)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = accept ? (early ? DONE : CALC) : IDLE;
            CALC: state_nxt = cnt == '0 ? FIX : CALC;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = resp_ready ? IDLE : DONE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
            result  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rem     <= '0;
                dvd     <= a_abs;
                dvs     <= b_abs;
                neg_q   <= (s1 ^ s2) & (op2 != '0);
                neg_r   <= s1;
                sel_rem <= div_ctrl[1];
                cnt     <= CW'(DATA_WIDTH-1);
`ifdef DIV_EARLY_OUT_EN
                if (early) result <= eo_res;
`endif
            end
            if (state == CALC && !flush) begin
                rem <= rem_nxt;
                dvd <= dvd_nxt;
                cnt <= cnt - 1'b1;
            end
            if (state == FIX && !flush)
                result <= sel_rem ? DATA_WIDTH'(abs_val(MAX_W'(rem[DATA_WIDTH-1:0]), neg_r))
                                  : DATA_WIDTH'(abs_val(MAX_W'(dvd), neg_q));
        end
    end

endmodule

// File: tb/tb_div_mc.sv
// tb_div_mc: directed scoreboard bench for div_mc (queue of expected results, separate monitor).
module tb_div_mc;

    localparam int W   = 32;
    localparam int LAT = W + 2;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, req_valid = 1'b0, resp_ready = 1'b1;
    logic [W-1:0] op1 = '0, op2 = '0;
    logic [2:0]   div_ctrl = '0;
    logic         req_ready, resp_valid, busy;
    logic [W-1:0] result;

    div_mc #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op1        (op1),
        .op2        (op2),
        .div_ctrl   (div_ctrl),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           start;
        int           lat;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0;
    bit   seen = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+2; presents one request and records its expectation.
    task automatic issue(input string name, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input bit eo, input bit push);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (!req_ready) check({name, " ready_timeout"}, W'(req_ready), W'(1));
        req_valid = 1'b1;
        div_ctrl  = f;
        op1       = a;
        op2       = b;
        if (push) sb.push_back('{exp, cyc + 1, (eo && EO) ? 1 : LAT, name});
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: %0d responses still outstanding, expected 0", name, sb.size());
            sb.delete();
            seen = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: result %h with resp_valid, expected no response", result);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    check({sb[0].name, " latency"}, W'(cyc - sb[0].start + 1), W'(sb[0].lat));
                    check({sb[0].name, " req_ready"}, W'(req_ready), W'(0));
                end
                if (resp_ready) begin
                    check(sb[0].name, result, sb[0].res);
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", W'(req_ready), W'(1));
        check("rst_resp_valid", W'(resp_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_result", result, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        issue("divu_100_7",   3'b101, 32'd100,       32'd7,          32'd14,         1'b0, 1'b1);
        issue("remu_100_7",   3'b111, 32'd100,       32'd7,          32'd2,          1'b0, 1'b1);
        issue("div_m7_2",     3'b100, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,   1'b0, 1'b1);
        issue("rem_m7_2",     3'b110, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFF,   1'b0, 1'b1);
        issue("rem_7_m2",     3'b110, 32'd7,         32'hFFFFFFFE,   32'd1,          1'b0, 1'b1);
        issue("div_x_0",      3'b100, 32'h1234,      32'd0,          32'hFFFFFFFF,   1'b1, 1'b1);
        issue("rem_x_0",      3'b110, 32'h1234,      32'd0,          32'h1234,       1'b1, 1'b1);
        issue("div_m7_0",     3'b100, 32'hFFFFFFF9,  32'd0,          32'hFFFFFFFF,   1'b1, 1'b1);
        issue("rem_m7_0",     3'b110, 32'hFFFFFFF9,  32'd0,          32'hFFFFFFF9,   1'b1, 1'b1);
        issue("div_ovf",      3'b100, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   1'b1, 1'b1);
        issue("rem_ovf",      3'b110, 32'h80000000,  32'hFFFFFFFF,   32'd0,          1'b1, 1'b1);
        issue("divu_big",     3'b101, 32'h80000000,  32'hFFFFFFFF,   32'd0,          1'b1, 1'b1);
        issue("divu_max_1",   3'b101, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   1'b0, 1'b1);
        issue("div_m100_m7",  3'b100, 32'hFFFFFF9C,  32'hFFFFFFF9,   32'd14,         1'b0, 1'b1);
        issue("rem_m100_7",   3'b110, 32'hFFFFFF9C,  32'd7,          32'hFFFFFFFE,   1'b0, 1'b1);
        issue("divu_3_5",     3'b101, 32'd3,         32'd5,          32'd0,          1'b1, 1'b1);
        issue("remu_3_5",     3'b111, 32'd3,         32'd5,          32'd3,          1'b1, 1'b1);
        issue("div_8_0",      3'b100, 32'd8,         32'd0,          32'hFFFFFFFF,   1'b1, 1'b1);
        wait_done("directed");

        issue("illegal_f3", 3'b011, 32'd50, 32'd5, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("illegal_busy", W'(busy), W'(0));
        check("illegal_req_ready", W'(req_ready), W'(1));
        @(posedge clk); #2;

        resp_ready = 1'b0;
        issue("hold_divu", 3'b101, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b1);
        begin
            int n = 0;
            while (!resp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (5) begin
            @(negedge clk);
            check("hold_resp_valid", W'(resp_valid), W'(1));
            check("hold_result", result, 32'd100);
            check("hold_req_ready", W'(req_ready), W'(0));
        end
        @(posedge clk); #2;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_req_ready", W'(req_ready), W'(1));
        check("release_resp_valid", W'(resp_valid), W'(0));
        wait_done("hold");

        issue("flush_divu", 3'b101, 32'd1000, 32'd7, 32'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("pre_flush_busy", W'(busy), W'(1));
        @(posedge clk); #2;
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        @(negedge clk);
        check("flush_resp_valid", W'(resp_valid), W'(0));
        check("flush_busy", W'(busy), W'(0));
        check("flush_req_ready", W'(req_ready), W'(1));
        repeat (40) @(posedge clk);
        #2;
        issue("post_flush_divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1);
        wait_done("post_flush");

        issue("reset_divu", 3'b101, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_req_ready", W'(req_ready), W'(1));
        check("midrst_resp_valid", W'(resp_valid), W'(0));
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_result", result, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        issue("post_rst_divu", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
        wait_done("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_mc.md
Name: div_mc

Overview:
- Multi-cycle iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Responder side of the execute-stage M-unit request interface: the pipeline issues a request with valid/ready and stalls until the result handshake completes.
- Replaces the single-cycle divider on timing-critical builds; the multiplier path is unchanged.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and at least 4.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  pipeline flush; aborts any in-flight operation.
- req_valid  input  1  request valid.
- req_ready  output  1  divider can accept a request.
- op1  input  DATA_WIDTH  dividend (rs1).
- op2  input  DATA_WIDTH  divisor (rs2).
- div_ctrl  input  3  func3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; 0xx is illegal and ignored.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts result.
- result  output  DATA_WIDTH  quotient or remainder.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; req_ready=1, resp_valid=0, result=0, busy=0; all internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE: req_ready=1. Handshake (req_valid & req_ready & div_ctrl[2]):
  - latch |op1|, |op2| (signed ops negate when MSB set; unsigned ops pass through);
  - latch neg_q = sign(op1)^sign(op2) & (op2!=0) for DIV;
  - latch neg_r = sign(op1) for REM;
  - latch sel_rem = div_ctrl[1];
  - iteration counter = DATA_WIDTH-1; go to CALC.
  - Request with div_ctrl[2]=0: not accepted, no state change.
- CALC: one quotient bit per cycle.
  - Remainder register R (DATA_WIDTH+1 bits) shifts in the dividend MSB.
  - Trial subtract of the divisor: if non-negative, keep the difference and set q bit=1; otherwise q bit=0.
  - After DATA_WIDTH cycles (counter reaches 0), go to FIX.
- FIX: one cycle. Apply two's-complement negation per neg_q/neg_r, register result, go to DONE.
- DONE: resp_valid=1, result held stable until resp_ready.
  - On resp_valid & resp_ready, go to IDLE; req_ready rises the next cycle, so there is no same-cycle re-accept.
- Latency: request handshake at edge N gives resp_valid high from edge N+DATA_WIDTH+2 (34 cycles at default).
- Divide by zero: quotient = all ones (DIVU and DIV), remainder = op1. The algorithm yields this naturally; neg_q is forced 0.
- Signed overflow (op1=most negative, op2=-1): quotient = most negative, remainder = 0. No trap.
- Negating the most negative value wraps to itself; treated as an unsigned magnitude of 2^(DATA_WIDTH-1).
- flush has priority over every transition except reset:
  - any state goes to IDLE next cycle; resp_valid drops next cycle; result is not updated;
  - a request presented in the same cycle as flush is not accepted.
- req_ready=0 in CALC, FIX and DONE. Inputs are ignored outside IDLE.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: at the IDLE handshake, op2==0, signed overflow, or |op1|<|op2| skip CALC. The special-case result is computed directly and the block enters DONE next cycle (resp_valid at N+1).
  - |op1|<|op2| gives quotient 0 and remainder op1.
- Undefined: every legal request takes the full DATA_WIDTH+2 latency. Results are identical in both builds.

Decomposition:
- Shared package (M-unit package):
  - func3 encoding constants DIV_F3, DIVU_F3, REM_F3, REMU_F3;
  - enum typedef div_state_t {IDLE, CALC, FIX, DONE};
  - function abs_val for conditional negation.
- One natural sub-module: div_step, the combinational one-bit restoring step (shift, trial subtract, select); instantiated once and reused each CALC cycle.

Test Plan:
- DIVU 100/7, resp_ready=1 -> resp_valid at N+34, result 14; REMU same operands -> 2; req_ready low throughout.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIV x/0 with x=0x1234 -> 0xFFFFFFFF; REM x/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Hold resp_ready=0 for 5 cycles after DONE -> result and resp_valid stable, req_ready=0; release -> IDLE next cycle, req_ready=1.
- Assert flush at CALC cycle 10 -> IDLE next cycle, no resp_valid. A new DIVU 9/3 then returns 3 with full latency.
- With DIV_EARLY_OUT_EN: DIVU 3/5 -> resp_valid at N+1, result 0; DIV 8/0 -> N+1, 0xFFFFFFFF. Without the macro: same values at N+34. Reset mid-CALC -> all outputs return to reset values.
